// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// Latency: none, wires only; rdata is consumed in the same cycle ready is high.
// Backpressure: memory holds off the fetch by keeping imem_ready low.
//
// Signals:
//   imem_addr  - fetch address (fetch stage -> memory)
//   imem_req   - fetch request valid (fetch stage -> memory)
//   imem_rdata - instruction word (memory -> fetch stage)
//   imem_ready - imem_rdata valid this cycle (memory -> fetch stage)
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    // Fetch stage side.
    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ready
    );

    // Instruction memory side.
    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from imem and fills the F/D register.
// Latency: the word fetched at pc_f in cycle N is on instr_d in cycle N+1.
// Backpressure: stall_f holds PC and F/D; imem_ready=0 holds PC and inserts bubbles.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-low reset
//   imem                  - instruction memory bus (fetch_stage_if.master)
//   next_pc               - PC chosen by next-PC logic, loaded on advance
//   stall_f, flush_d      - hazard controls (hold fetch / turn F/D into a bubble)
//   pc_f, pc4_f           - current fetch PC and its +4 successor
//   instr_d, pc_d,
//   valid_d, exc_d,
//   excode_d              - F/D pipeline register contents
//
// Optional feature: define FETCH_ADDR_CHECK_EN to flag misaligned or out-of-range
// fetch PCs as an AdEL exception instead of fetching them.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master imem,
    input  logic [31:0]   next_pc,
    input  logic          stall_f,
    input  logic          flush_d,
    output logic [31:0]   pc_f,
    output logic [31:0]   pc4_f,
    output logic [31:0]   instr_d,
    output logic [31:0]   pc_d,
    output logic          valid_d,
    output logic          exc_d,
    output logic [4:0]    excode_d
);

    // ------------------------------------------------------------------
    // Control FSM encoding
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_RUN  = 1'b0,   // fetch outstanding, memory answered last time
        ST_WAIT = 1'b1    // memory not ready, PC held until it answers
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Fetch PC register
    logic [31:0] pcf_q;
    logic [31:0] pcf_d;

    // F/D pipeline register
    logic [31:0] fd_instr_q;
    logic [31:0] fd_instr_d;
    logic [31:0] fd_pc_q;
    logic [31:0] fd_pc_d;
    logic        fd_valid_q;
    logic        fd_valid_d;

    // Fetch control
    logic        bad_pc;     // current PC must not be fetched
    logic        req;        // request presented to memory
    logic        advance;    // PC moves on and F/D captures this cycle

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [31:0] ADDR_LO  = 32'h0000_3000;
    localparam logic [31:0] ADDR_HI  = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    logic        fd_exc_q;
    logic        fd_exc_d;
    logic [4:0]  fd_code_q;
    logic [4:0]  fd_code_d;

    // Only word-aligned PCs inside the instruction window are fetched.
    assign bad_pc = (pcf_q[1:0] != 2'b00) || (pcf_q < ADDR_LO) || (pcf_q > ADDR_HI);
`else
    assign bad_pc = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Combinational outputs (from registered state only; next_pc never
    // reaches an output in the same cycle)
    // ------------------------------------------------------------------
    assign req            = reset & ~bad_pc;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pcf_q;
    assign pc_f           = pcf_q;
    assign pc4_f          = pcf_q + 32'd4;   // carry out discarded, wraps at 2^32

    // A bad PC advances on its own: there is no memory answer to wait for.
    assign advance = (imem.imem_ready | bad_pc) & ~stall_f;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
`ifdef FETCH_ADDR_CHECK_EN
        fd_exc_d   = fd_exc_q;
        fd_code_d  = fd_code_q;
`endif

        // FSM: track whether the outstanding fetch is still waiting.
        case (state_q)
            ST_RUN:  if (req && !imem.imem_ready) state_d = ST_WAIT;
            ST_WAIT: if (imem.imem_ready)         state_d = ST_RUN;
            default:                              state_d = ST_RUN;
        endcase

        // PC: moves only on advance; stall and memory wait both hold it.
        if (advance) begin
            pcf_d = next_pc;
        end

        // F/D: flush beats stall-hold, stall beats capture, and a cycle
        // that neither holds nor captures inserts a bubble.
        if (flush_d || (!stall_f && !advance)) begin
            fd_instr_d = NOP_INSTR;
            fd_pc_d    = pcf_q;
            fd_valid_d = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
            fd_exc_d   = 1'b0;
            fd_code_d  = 5'd0;
`endif
        end else if (advance) begin
            fd_pc_d    = pcf_q;
            fd_valid_d = 1'b1;
`ifdef FETCH_ADDR_CHECK_EN
            // Faulting fetch carries a NOP with the exception attached.
            fd_instr_d = bad_pc ? NOP_INSTR : imem.imem_rdata;
            fd_exc_d   = bad_pc;
            fd_code_d  = bad_pc ? EXC_ADEL : 5'd0;
`else
            fd_instr_d = imem.imem_rdata;
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers. Reset wins over everything, so a memory answer that
    // arrives in the same cycle as reset is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pcf_q      <= RESET_PC;
            fd_instr_q <= NOP_INSTR;
            fd_pc_q    <= 32'd0;
            fd_valid_q <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
            fd_exc_q   <= 1'b0;
            fd_code_q  <= 5'd0;
`endif
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
`ifdef FETCH_ADDR_CHECK_EN
            fd_exc_q   <= fd_exc_d;
            fd_code_q  <= fd_code_d;
`endif
        end
    end

    assign instr_d = fd_instr_q;
    assign pc_d    = fd_pc_q;
    assign valid_d = fd_valid_q;

`ifdef FETCH_ADDR_CHECK_EN
    assign exc_d    = fd_exc_q;
    assign excode_d = fd_code_q;
`else
    assign exc_d    = 1'b0;
    assign excode_d = 5'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic.
// Latency: one check set before each clock edge and one just after it.
// Backpressure: imem_ready, stall_f and flush_d are driven by the bench.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        stall_f;
    logic        flush_d;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        exc_d;
    logic [4:0]  excode_d;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_stage_if imem_bus ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imem_bus),
        .next_pc  (next_pc),
        .stall_f  (stall_f),
        .flush_d  (flush_d),
        .pc_f     (pc_f),
        .pc4_f    (pc4_f),
        .instr_d  (instr_d),
        .pc_d     (pc_d),
        .valid_d  (valid_d),
        .exc_d    (exc_d),
        .excode_d (excode_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0019_660D) + 32'h3C6E_F35F;
    endfunction

    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    function automatic logic is_bad(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model of architectural state.
    logic        m_known = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic        m_exc;
    logic [4:0]  m_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock,
    // advance the model, check registered outputs.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic rdy, input logic [31:0] npc);
        logic        b;
        logic        go;
        reset   = r;
        stall_f = s;
        flush_d = f;
        imem_bus.imem_ready = rdy;
        next_pc = npc;
        #1;
        if (!r) begin
            chk("imem_req_rst", {31'd0, imem_bus.imem_req}, 32'd0);
        end else if (m_known) begin
            chk("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, !is_bad(m_pc)});
            chk("imem_addr", imem_bus.imem_addr, m_pc);
            chk("pc4_f", pc4_f, m_pc + 32'd4);
        end
        @(posedge clk);
        if (!r) begin
            m_known = 1'b1;
            m_pc    = RESET_PC;
            m_instr = NOP_INSTR;
            m_pcd   = 32'd0;
            m_valid = 1'b0;
            m_exc   = 1'b0;
            m_code  = 5'd0;
        end else begin
            b  = is_bad(m_pc);
            go = (rdy || b) && !s;
            if (f || (!s && !go)) begin
                m_instr = NOP_INSTR; m_pcd = m_pc; m_valid = 1'b0; m_exc = 1'b0; m_code = 5'd0;
            end else if (go) begin
                m_instr = b ? NOP_INSTR : mem_word(m_pc);
                m_pcd   = m_pc;
                m_valid = 1'b1;
                m_exc   = b;
                m_code  = b ? 5'd4 : 5'd0;
            end
            if (go) m_pc = npc;
        end
        #1;
        chk("pc_f", pc_f, m_pc);
        chk("instr_d", instr_d, m_instr);
        chk("pc_d", pc_d, m_pcd);
        chk("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        chk("exc_d", {31'd0, exc_d}, {31'd0, m_exc});
        chk("excode_d", {27'd0, excode_d}, {27'd0, m_code});
    endtask

    initial begin
        logic [31:0] npc;
        logic        r, s, f, rdy;
        int          sel;

        reset = 1'b0; stall_f = 1'b0; flush_d = 1'b0; next_pc = 32'd0;
        imem_bus.imem_ready = 1'b0;

        // Reset, with memory claiming ready to show it is ignored.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("rst_pc_f", pc_f, 32'h0000_3000);
        chk("rst_valid_d", {31'd0, valid_d}, 32'd0);

        // Zero-wait sequential fetch 0x3000 -> 0x3004 -> 0x3008.
        step(1'b1, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        chk("seq_valid", {31'd0, valid_d}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        chk("seq_pc", pc_f, 32'h0000_3008);

        // Memory not ready for three cycles at 0x3008.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
            chk("wait_pc", pc_f, 32'h0000_3008);
            chk("wait_bubble", {31'd0, valid_d}, 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        chk("wait_instr", instr_d, mem_word(32'h0000_3008));
        step(1'b1, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);

        // Stall holds everything, stall+flush bubbles F/D but keeps the PC.
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_5550);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_5550);
        chk("stall_instr", instr_d, mem_word(32'h0000_300C));
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5550);
        chk("stflush_pc", pc_f, 32'h0000_3010);
        chk("stflush_instr", instr_d, NOP_INSTR);

        // Jump from 0x3010 to 0x3400.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3400);
        chk("jump_pc", pc_f, 32'h0000_3400);
        chk("jump_pc_d", pc_d, 32'h0000_3010);

        // PC at the top of the address space: pc4_f wraps to zero.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        #1;
        chk("pc4_wrap", pc4_f, 32'h0000_0000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3000);

        // Misaligned target.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3002);
`ifdef FETCH_ADDR_CHECK_EN
        #1;
        chk("bad_req", {31'd0, imem_bus.imem_req}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3004);
        chk("bad_exc", {31'd0, exc_d}, 32'd1);
        chk("bad_code", {27'd0, excode_d}, 32'd4);
        chk("bad_pc_d", pc_d, 32'h0000_3002);
`else
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3004);
        chk("unal_instr", instr_d, mem_word(32'h0000_3002));
`endif

        // Reset taken while waiting on memory, with ready high that cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        chk("rstwait_pc", pc_f, 32'h0000_3000);
        chk("rstwait_instr", instr_d, NOP_INSTR);
        chk("rstwait_pc_d", pc_d, 32'd0);
        chk("rstwait_valid", {31'd0, valid_d}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) >= 3);
            s   = ($urandom_range(0, 99) < 20);
            f   = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 70);
            sel = $urandom_range(0, 9);
            if (sel < 6)       npc = m_pc + 32'd4;
            else if (sel < 8)  npc = {$urandom_range(32'h0C00, 32'h1BFF), 2'b00};
            else if (sel == 8) npc = $urandom;
            else               npc = m_pc;
            step(r, s, f, rdy, npc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
